// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, frame limits and NBits clamp.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
  localparam int NBITS_MAX = 8;
  function automatic logic [3:0] eff_nbits(input logic [3:0] n);
    return (n == 4'd0 || n > 4'(NBITS_MAX)) ? 4'(NBITS_MAX) : n;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer with falling-edge detect on the synchronized line.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic level,
  output logic fall
);
  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;
  always_comb begin
    s1_d = rx;
    s2_d = s1_q;
    prev_d = s2_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      prev_q <= prev_d;
    end
  end
  assign level = s2_q;
  assign fall = prev_q & ~s2_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver (start, 1..8 data LSB first, stop) with valid/ack holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Rx,
  input  logic [3:0] NBits,
  input  logic       RxAck,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       RxDone,
  output logic       FrameErr,
  output logic       Overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  uart_state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] bit_q, bit_d, nb_q, nb_d;
  logic [7:0] sh_q, sh_d, data_q, data_d;
  logic valid_q, valid_d, done_q, done_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic level, fall;
  uart_rx_sync u_sync (.clk(Clk), .rst(Rst), .rx(Rx), .level(level), .fall(fall));
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    nb_d = nb_q;
    sh_d = sh_q;
    data_d = data_q;
    valid_d = valid_q;
    done_d = 1'b0;
    ferr_d = 1'b0;
    ovr_d = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        nb_d = eff_nbits(NBits);
        tick_d = '0;
        bit_d = '0;
        state_d = START;
      end
      START: if (Tick) begin
        tick_d = (tick_q == HALF) ? '0 : tick_q + 1'b1;
        if (tick_q == HALF) begin
          bit_d = '0;
          sh_d = '0;
          state_d = level ? IDLE : DATA;
        end
      end
      DATA: if (Tick) begin
        tick_d = (tick_q == LAST) ? '0 : tick_q + 1'b1;
        if (tick_q == LAST) begin
          // New bit enters at the top of the NBits-wide field, keeping the result right-justified.
          sh_d = (sh_q >> 1) | (8'(level) << (nb_q - 4'd1));
          bit_d = (bit_q == nb_q - 4'd1) ? 4'd0 : bit_q + 4'd1;
          state_d = (bit_q == nb_q - 4'd1) ? STOP : DATA;
        end
      end
      STOP: if (Tick) begin
        tick_d = (tick_q == LAST) ? '0 : tick_q + 1'b1;
        if (tick_q == LAST) begin
          done_d = level;
          ferr_d = ~level;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_d) begin
      data_d = (!valid_q || RxAck) ? sh_q : data_q;
      valid_d = 1'b1;
      ovr_d = valid_q && !RxAck;
    end else if (RxAck) begin
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      nb_q <= 4'(NBITS_MAX);
      sh_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      nb_q <= nb_d;
      sh_q <= sh_d;
      data_q <= data_d;
      valid_q <= valid_d;
      done_q <= done_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  end
  assign RxData = data_q;
  assign RxValid = valid_q;
  assign RxDone = done_q;
  assign FrameErr = ferr_q;
  assign Overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed vector table plus hand sequences for glitch, ack timing, reset and break.
module tb_uart_rx;
  logic Clk = 1'b0, Rst = 1'b1, Tick = 1'b0, Rx = 1'b1, RxAck = 1'b0;
  logic [3:0] NBits = 4'd8;
  logic [7:0] RxData;
  logic RxValid, RxDone, FrameErr, Overrun;
  int checks = 0, errors = 0, done_n = 0, ferr_n = 0, ovr_n = 0;
  int d0, f0, o0;
  typedef struct {
    logic [3:0] nb;
    logic [7:0] din;
    bit ack;
    logic [7:0] exp_data;
    int exp_ovr;
  } vec_t;
  vec_t vecs[7];

  uart_rx #(.OVERSAMPLE(4)) dut (
    .Clk(Clk), .Rst(Rst), .Tick(Tick), .Rx(Rx), .NBits(NBits), .RxAck(RxAck),
    .RxData(RxData), .RxValid(RxValid), .RxDone(RxDone), .FrameErr(FrameErr), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  initial begin
    int t = 0;
    forever begin
      @(negedge Clk);
      t = (t + 1) % 4;
      Tick = (t == 0);
    end
  end

  initial forever begin
    @(posedge Clk);
    #1;
    done_n += int'(RxDone);
    ferr_n += int'(FrameErr);
    ovr_n += int'(Overrun);
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put_bit(input logic b);
    Rx = b;
    repeat (16) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [3:0] nb, input logic [7:0] d, input logic stop);
    int n;
    n = (nb == 4'd0 || nb > 4'd8) ? 8 : int'(nb);
    NBits = nb;
    put_bit(1'b0);
    NBits = 4'd2;
    for (int i = 0; i < n; i++) put_bit(d[i]);
    put_bit(stop);
    if (stop) put_bit(1'b1);
  endtask

  task automatic do_ack(input string name);
    chk({name, " valid before ack"}, 32'(RxValid), 32'd1);
    RxAck = 1'b1;
    @(negedge Clk);
    RxAck = 1'b0;
    chk({name, " valid after ack"}, 32'(RxValid), 32'd0);
  endtask

  task automatic mark();
    d0 = done_n;
    f0 = ferr_n;
    o0 = ovr_n;
  endtask

  initial begin
    vecs[0] = '{4'd8,  8'hA5, 1'b1, 8'hA5, 0};
    vecs[1] = '{4'd5,  8'h13, 1'b1, 8'h13, 0};
    vecs[2] = '{4'd0,  8'hFF, 1'b1, 8'hFF, 0};
    vecs[3] = '{4'd3,  8'hFD, 1'b1, 8'h05, 0};
    vecs[4] = '{4'd12, 8'hC3, 1'b1, 8'hC3, 0};
    vecs[5] = '{4'd8,  8'h11, 1'b0, 8'h11, 0};
    vecs[6] = '{4'd8,  8'h22, 1'b0, 8'h11, 1};
    repeat (3) @(negedge Clk);
    chk("reset RxData", 32'(RxData), 32'h00);
    chk("reset RxValid", 32'(RxValid), 32'd0);
    chk("reset pulses", {29'd0, RxDone, FrameErr, Overrun}, 32'd0);
    Rst = 1'b0;
    repeat (8) @(negedge Clk);

    for (int i = 0; i < 7; i++) begin
      mark();
      send_frame(vecs[i].nb, vecs[i].din, 1'b1);
      chk($sformatf("vec%0d done", i), 32'(done_n - d0), 32'd1);
      chk($sformatf("vec%0d ferr", i), 32'(ferr_n - f0), 32'd0);
      chk($sformatf("vec%0d overrun", i), 32'(ovr_n - o0), 32'(vecs[i].exp_ovr));
      chk($sformatf("vec%0d data", i), 32'(RxData), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d valid", i), 32'(RxValid), 32'd1);
      if (vecs[i].ack) do_ack($sformatf("vec%0d", i));
    end

    mark();
    fork
      send_frame(4'd8, 8'h22, 1'b1);
      begin
        int k = 0, t = 0;
        while (t < 37 && k < 1000) begin
          @(posedge Clk);
          k++;
          if (k >= 4 && Tick) t++;
        end
        chk("ackcyc tick budget", 32'(t), 32'd37);
        repeat (4) @(negedge Clk);
        RxAck = 1'b1;
        @(posedge Clk);
        #1;
        chk("ackcyc done", 32'(RxDone), 32'd1);
        chk("ackcyc data", 32'(RxData), 32'h22);
        chk("ackcyc valid", 32'(RxValid), 32'd1);
        chk("ackcyc overrun", 32'(Overrun), 32'd0);
        @(negedge Clk);
        RxAck = 1'b0;
        @(posedge Clk);
        #1;
        chk("ackcyc done width", 32'(RxDone), 32'd0);
      end
    join
    chk("ackcyc overrun count", 32'(ovr_n - o0), 32'd0);
    do_ack("ackcyc");

    mark();
    Rx = 1'b0;
    repeat (4) @(negedge Clk);
    Rx = 1'b1;
    repeat (48) @(negedge Clk);
    chk("glitch done", 32'(done_n - d0), 32'd0);
    chk("glitch ferr", 32'(ferr_n - f0), 32'd0);
    send_frame(4'd8, 8'h42, 1'b1);
    chk("post-glitch done", 32'(done_n - d0), 32'd1);
    chk("post-glitch data", 32'(RxData), 32'h42);

    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    Rx = 1'b1;
    repeat (8) @(negedge Clk);
    Rst = 1'b1;
    mark();
    @(negedge Clk);
    chk("midreset RxData", 32'(RxData), 32'h00);
    chk("midreset RxValid", 32'(RxValid), 32'd0);
    chk("midreset pulses", {29'd0, RxDone, FrameErr, Overrun}, 32'd0);
    Rst = 1'b0;
    repeat (64) @(negedge Clk);
    chk("midreset no done", 32'(done_n - d0), 32'd0);
    chk("midreset no ferr", 32'(ferr_n - f0), 32'd0);
    send_frame(4'd8, 8'h3C, 1'b1);
    chk("post-reset done", 32'(done_n - d0), 32'd1);
    chk("post-reset data", 32'(RxData), 32'h3C);
    do_ack("post-reset");

    mark();
    send_frame(4'd8, 8'h55, 1'b0);
    repeat (96) @(negedge Clk);
    chk("break ferr", 32'(ferr_n - f0), 32'd1);
    chk("break done", 32'(done_n - d0), 32'd0);
    chk("break valid", 32'(RxValid), 32'd0);
    chk("break overrun", 32'(ovr_n - o0), 32'd0);
    Rx = 1'b1;
    repeat (48) @(negedge Clk);
    chk("break release ferr", 32'(ferr_n - f0), 32'd1);
    chk("break release done", 32'(done_n - d0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
